// File: rtl/md_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: op codes, controller states
// and small helpers used by both the RTL and the bench.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MADD  = 3'd4;
    localparam logic [2:0] MD_MADDU = 3'd5;
    localparam logic [2:0] MD_MSUB  = 3'd6;
    localparam logic [2:0] MD_MSUBU = 3'd7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    // Divide latency: one step per bit plus the sign-fix cycle.
    function automatic int unsigned div_lat(input int unsigned width);
        return width + 1;
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Even op codes are the signed variants.
    function automatic logic op_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring divider core: unsigned magnitudes, one quotient bit per cycle.
// done is high during the cycle in which the final step is taken.
module div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             active_q;
    logic [WIDTH:0]   trial, diff;

    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]};
        diff  = trial - {1'b0, dvs_q};
        done  = active_q && (cnt_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (abort) begin
            active_q <= 1'b0;
        end else if (load) begin
            quo_q    <= dividend;
            rem_q    <= '0;
            dvs_q    <= divisor;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                active_q <= 1'b0;
            end
            // Borrow out of the trial subtraction means restore.
            if (!diff[WIDTH]) begin
                rem_q <= diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_q <= trial[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/multdiv_param.sv
// Iterative multiply/accumulate/divide unit with HI/LO registers for the E stage.
// Multiplies hold a registered product for MULT_LAT cycles; divides run WIDTH+1 cycles.
module multdiv_param
    import md_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MULT_LAT = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mdctr,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hiwrite,
    input  logic             lowrite,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hio,
    output logic [WIDTH-1:0] loo
);

    localparam int unsigned CW = $clog2(MULT_LAT + 1);
    localparam int unsigned DW = 2 * WIDTH;

    logic [1:0]       state_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       op_q;
    logic [DW-1:0]    prod_q, acc_q;
    logic [WIDTH-1:0] hi_q, lo_q, a_q;
    logic             neg_quo_q, neg_rem_q, dzero_q;

    logic             sgn, launch;
    logic [DW-1:0]    a_ext, b_ext, mul_res;
    logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
    logic             div_done;
    logic [WIDTH-1:0] div_quo, div_rem;

    always_comb begin
        sgn    = op_signed(mdctr);
        launch = start && !cancel && (state_q == S_IDLE);
        a_ext  = sgn ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
        b_ext  = sgn ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
        a_mag  = (sgn && A[WIDTH-1]) ? -A : A;
        b_mag  = (sgn && B[WIDTH-1]) ? -B : B;
        unique case (op_q)
            MD_MADD, MD_MADDU: mul_res = acc_q + prod_q;
            MD_MSUB, MD_MSUBU: mul_res = acc_q - prod_q;
            default:           mul_res = prod_q;
        endcase
        quo_fix = neg_quo_q ? -div_quo : div_quo;
        rem_fix = neg_rem_q ? -div_rem : div_rem;
    end

    div_iter #(
        .WIDTH (WIDTH)
    ) u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .load      (launch && op_is_div(mdctr)),
        .abort     (cancel && (state_q != S_IDLE)),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= MD_MULT;
            prod_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            a_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dzero_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (hiwrite) hi_q <= A;
                    if (lowrite) lo_q <= A;
                    if (launch) begin
                        op_q  <= mdctr;
                        // Accumulate uses HI/LO from before any same-cycle MTHI/MTLO.
                        acc_q <= {hi_q, lo_q};
                        a_q   <= A;
                        if (op_is_div(mdctr)) begin
                            state_q   <= S_DIV;
                            neg_quo_q <= sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_rem_q <= sgn && A[WIDTH-1];
                            dzero_q   <= (B == '0);
                        end else begin
                            state_q <= S_MUL;
                            cnt_q   <= CW'(MULT_LAT - 1);
                            prod_q  <= a_ext * b_ext;
                        end
                    end
                end
                S_MUL: begin
                    if (cancel) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == '0) begin
                        {hi_q, lo_q} <= mul_res;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DIV: begin
                    if (cancel) begin
                        state_q <= S_IDLE;
                    end else if (div_done) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!cancel) begin
                        if (dzero_q) begin
                            hi_q <= a_q;
                            lo_q <= '1;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);
    assign hio  = hi_q;
    assign loo  = lo_q;

endmodule
